// File: rtl/e203_exu_alu_oitf_pkg.sv
// Shared widths and entry type for the ALU outstanding-instruction track FIFO.
// Optional macro: E203_OITF_RET_PC_EN adds a PC field to each entry.
package e203_exu_alu_oitf_pkg;

  localparam int OITF_DEPTH = 2;
  localparam int ITAG_W     = $clog2(OITF_DEPTH);
  localparam int RFIDX_W    = 5;
  localparam int PC_W       = 32;

  typedef logic [ITAG_W-1:0]  itag_t;
  typedef logic [RFIDX_W-1:0] rfidx_t;
  typedef logic [PC_W-1:0]    pc_t;

  typedef struct packed {
    logic   rdwen;
    rfidx_t rdidx;
`ifdef E203_OITF_RET_PC_EN
    pc_t    pc;
`endif
  } oitf_entry_t;

endpackage

// File: rtl/e203_exu_alu_oitf_if.sv
// Dispatch / write-back / hazard signals of the OITF, bundled with directional views.
interface e203_exu_alu_oitf_if;
  import e203_exu_alu_oitf_pkg::*;

  logic   dis_ena;
  logic   dis_ready;
  logic   disp_i_rdwen;
  rfidx_t disp_i_rdidx;
  logic   disp_i_rs1en;
  rfidx_t disp_i_rs1idx;
  logic   disp_i_rs2en;
  rfidx_t disp_i_rs2idx;
  pc_t    disp_i_pc;
  itag_t  dis_ptr;
  logic   oitf_ret_ena;
  itag_t  oitf_ret_ptr;
  rfidx_t oitf_ret_rdidx;
  logic   oitf_ret_rdwen;
  pc_t    oitf_ret_pc;
  logic   oitf_empty;
  logic   oitfrd_match_disprs1;
  logic   oitfrd_match_disprs2;
  logic   oitfrd_match_disprd;

  modport master (
    output dis_ena, disp_i_rdwen, disp_i_rdidx, disp_i_rs1en, disp_i_rs1idx,
           disp_i_rs2en, disp_i_rs2idx, disp_i_pc, oitf_ret_ena,
    input  dis_ready, dis_ptr, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen,
           oitf_ret_pc, oitf_empty, oitfrd_match_disprs1, oitfrd_match_disprs2,
           oitfrd_match_disprd
  );

  modport slave (
    input  dis_ena, disp_i_rdwen, disp_i_rdidx, disp_i_rs1en, disp_i_rs1idx,
           disp_i_rs2en, disp_i_rs2idx, disp_i_pc, oitf_ret_ena,
    output dis_ready, dis_ptr, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen,
           oitf_ret_pc, oitf_empty, oitfrd_match_disprs1, oitfrd_match_disprs2,
           oitfrd_match_disprd
  );
endinterface

// File: rtl/e203_exu_oitf_ptr.sv
// Circular itag counter with a wrap flag; the flag disambiguates full from empty.
module e203_exu_oitf_ptr
  import e203_exu_alu_oitf_pkg::*;
#(
  parameter int DEPTH = OITF_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_inc,
  output itag_t o_ptr,
  output logic  o_flag
);

  itag_t r_ptr;
  logic  r_flag;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_flag <= 1'b0;
    end else if (i_inc) begin
      if (r_ptr == itag_t'(DEPTH - 1)) begin
        r_ptr  <= '0;
        r_flag <= ~r_flag;
      end else begin
        r_ptr  <= r_ptr + itag_t'(1);
      end
    end
  end

  assign o_ptr  = r_ptr;
  assign o_flag = r_flag;

endmodule

// File: rtl/e203_exu_alu_oitf.sv
// Outstanding Instruction Track FIFO: itag allocation, head retire, RAW/WAW hazard flags.
// Optional macro: E203_OITF_RET_PC_EN stores per-entry PC and drives oitf_ret_pc from it.
module e203_exu_alu_oitf
  import e203_exu_alu_oitf_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  e203_exu_alu_oitf_if.slave    bus
);

  itag_t       w_alc_ptr;
  itag_t       w_ret_ptr;
  logic        w_alc_flag;
  logic        w_ret_flag;
  logic        w_empty;
  logic        w_full;
  logic        w_alc;
  logic        w_ret;
  oitf_entry_t w_new_entry;

  logic [OITF_DEPTH-1:0] r_vld;
  oitf_entry_t           r_entry [OITF_DEPTH];

  assign w_empty = (w_alc_ptr == w_ret_ptr) && (w_alc_flag == w_ret_flag);
  assign w_full  = (w_alc_ptr == w_ret_ptr) && (w_alc_flag != w_ret_flag);
  // A retire does not free a slot for an allocation in the same cycle.
  assign w_alc   = bus.dis_ena & ~w_full;
  assign w_ret   = bus.oitf_ret_ena & ~w_empty;

  e203_exu_oitf_ptr #(.DEPTH(OITF_DEPTH)) u_alc_ptr (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_alc),
    .o_ptr  (w_alc_ptr),
    .o_flag (w_alc_flag)
  );

  e203_exu_oitf_ptr #(.DEPTH(OITF_DEPTH)) u_ret_ptr (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_ret),
    .o_ptr  (w_ret_ptr),
    .o_flag (w_ret_flag)
  );

  assign w_new_entry.rdwen = bus.disp_i_rdwen;
  assign w_new_entry.rdidx = bus.disp_i_rdidx;
`ifdef E203_OITF_RET_PC_EN
  assign w_new_entry.pc    = bus.disp_i_pc;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^bus.disp_i_pc;
`endif

  // NOTE: entry payloads are reset (not just vld) so head outputs read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < OITF_DEPTH; i++) r_entry[i] <= '0;
    end else begin
      if (w_ret) r_vld[w_ret_ptr] <= 1'b0;
      if (w_alc) begin
        r_vld[w_alc_ptr]   <= 1'b1;
        r_entry[w_alc_ptr] <= w_new_entry;
      end
    end
  end

  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_hit_rd;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_hit_rs1 = 1'b0;
    w_hit_rs2 = 1'b0;
    w_hit_rd  = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (r_vld[i] && r_entry[i].rdwen) begin
        if (r_entry[i].rdidx == bus.disp_i_rs1idx) w_hit_rs1 = 1'b1;
        if (r_entry[i].rdidx == bus.disp_i_rs2idx) w_hit_rs2 = 1'b1;
        if (r_entry[i].rdidx == bus.disp_i_rdidx)  w_hit_rd  = 1'b1;
      end
    end
  end

  assign bus.oitfrd_match_disprs1 = w_hit_rs1 & bus.disp_i_rs1en;
  assign bus.oitfrd_match_disprs2 = w_hit_rs2 & bus.disp_i_rs2en;
  assign bus.oitfrd_match_disprd  = w_hit_rd  & bus.disp_i_rdwen;

  assign bus.dis_ready      = ~w_full;
  assign bus.dis_ptr        = w_alc_ptr;
  assign bus.oitf_empty     = w_empty;
  assign bus.oitf_ret_ptr   = w_ret_ptr;
  assign bus.oitf_ret_rdidx = r_entry[w_ret_ptr].rdidx;
  assign bus.oitf_ret_rdwen = r_entry[w_ret_ptr].rdwen;
`ifdef E203_OITF_RET_PC_EN
  assign bus.oitf_ret_pc    = r_entry[w_ret_ptr].pc;
`else
  assign bus.oitf_ret_pc    = '0;
`endif

endmodule

// File: tb/tb_e203_exu_alu_oitf.sv
// Bench for the OITF: queue-based reference model checked every cycle, plus literal pins.
module tb_e203_exu_alu_oitf;
  import e203_exu_alu_oitf_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  e203_exu_alu_oitf_if bus ();

  e203_exu_alu_oitf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order list of outstanding instructions.
  typedef struct {
    int          rdidx;
    bit          rdwen;
    logic [31:0] pc;
  } m_ent_t;

  m_ent_t m_q[$];
  int     m_alc_tag;
  int     m_ret_tag;
  bit     m_do_ret;
  bit     m_do_alc;
  m_ent_t m_new;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_alc_tag = 0;
      m_ret_tag = 0;
    end else begin
      m_do_ret = bus.oitf_ret_ena && (m_q.size() > 0);
      m_do_alc = bus.dis_ena && (m_q.size() < OITF_DEPTH);
      m_new.rdidx = int'(bus.disp_i_rdidx);
      m_new.rdwen = bus.disp_i_rdwen;
      m_new.pc    = bus.disp_i_pc;
      if (m_do_ret) begin
        void'(m_q.pop_front());
        m_ret_tag = (m_ret_tag + 1) % OITF_DEPTH;
      end
      if (m_do_alc) begin
        m_q.push_back(m_new);
        m_alc_tag = (m_alc_tag + 1) % OITF_DEPTH;
      end
    end
  end

  function automatic bit m_hazard(input int idx);
    foreach (m_q[k]) if (m_q[k].rdwen && m_q[k].rdidx == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    check("cyc empty", bus.oitf_empty, m_q.size() == 0);
    check("cyc dis_ready", bus.dis_ready, m_q.size() < OITF_DEPTH);
    check("cyc ret_ptr", bus.oitf_ret_ptr, m_ret_tag);
    check("cyc dis_ptr", bus.dis_ptr, m_alc_tag);
    if (m_q.size() > 0) begin
      check("cyc ret_rdidx", bus.oitf_ret_rdidx, m_q[0].rdidx);
      check("cyc ret_rdwen", bus.oitf_ret_rdwen, m_q[0].rdwen);
`ifdef E203_OITF_RET_PC_EN
      check("cyc ret_pc", bus.oitf_ret_pc, m_q[0].pc);
`endif
    end
`ifndef E203_OITF_RET_PC_EN
    check("cyc ret_pc", bus.oitf_ret_pc, 0);
`endif
    check("cyc match_rs1", bus.oitfrd_match_disprs1,
          bus.disp_i_rs1en && m_hazard(int'(bus.disp_i_rs1idx)));
    check("cyc match_rs2", bus.oitfrd_match_disprs2,
          bus.disp_i_rs2en && m_hazard(int'(bus.disp_i_rs2idx)));
    check("cyc match_rd", bus.oitfrd_match_disprd,
          bus.disp_i_rdwen && m_hazard(int'(bus.disp_i_rdidx)));
  end

  logic [31:0] pc_ctr = 32'h8000_0000;

  task automatic drive(input bit de, input bit rdwen, input int rd, input bit r1en, input int r1,
                       input bit r2en, input int r2, input bit ret);
    bus.dis_ena       = de;
    bus.disp_i_rdwen  = rdwen;
    bus.disp_i_rdidx  = rfidx_t'(rd);
    bus.disp_i_rs1en  = r1en;
    bus.disp_i_rs1idx = rfidx_t'(r1);
    bus.disp_i_rs2en  = r2en;
    bus.disp_i_rs2idx = rfidx_t'(r2);
    bus.oitf_ret_ena  = ret;
    pc_ctr            = pc_ctr + 32'd4;
    bus.disp_i_pc     = pc_ctr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset empty", bus.oitf_empty, 1);
    check("reset dis_ready", bus.dis_ready, 1);
    check("reset ret_ptr", bus.oitf_ret_ptr, 0);
    check("reset dis_ptr", bus.dis_ptr, 0);
    check("reset ret_rdidx", bus.oitf_ret_rdidx, 0);
    check("reset ret_rdwen", bus.oitf_ret_rdwen, 0);
    check("reset ret_pc", bus.oitf_ret_pc, 0);

    // Single allocation of x5
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    #1 check("t1 dis_ptr during alloc", bus.dis_ptr, 0);
    step(); idle(); #1;
    check("t1 empty", bus.oitf_empty, 0);
    check("t1 ret_ptr", bus.oitf_ret_ptr, 0);
    check("t1 ret_rdidx", bus.oitf_ret_rdidx, 5);
    check("t1 dis_ptr", bus.dis_ptr, 1);

    // Fill, overflow attempt, retire+alloc while full
    drive(1, 1, 6, 0, 0, 0, 0, 0); step(); idle(); #1;
    check("t2 full dis_ready", bus.dis_ready, 0);
    drive(1, 1, 9, 0, 0, 0, 0, 0); step(); idle(); #1;
    check("t2 rejected dis_ready", bus.dis_ready, 0);
    check("t2 rejected head", bus.oitf_ret_rdidx, 5);
    check("t2 rejected dis_ptr", bus.dis_ptr, 0);
    drive(1, 1, 10, 0, 0, 0, 0, 1); step(); idle(); #1;
    check("t2 ret-only dis_ready", bus.dis_ready, 1);
    check("t2 ret-only ret_ptr", bus.oitf_ret_ptr, 1);
    check("t2 ret-only head", bus.oitf_ret_rdidx, 6);
    check("t2 ret-only dis_ptr", bus.dis_ptr, 0);
    drive(1, 1, 8, 0, 0, 0, 0, 0); step();

    // Async reset with two valid entries (x6, x8)
    drive(0, 1, 8, 1, 8, 1, 6, 0);
    #1;
    check("t6 pre match_rs1", bus.oitfrd_match_disprs1, 1);
    check("t6 pre match_rs2", bus.oitfrd_match_disprs2, 1);
    check("t6 pre match_rd", bus.oitfrd_match_disprd, 1);
    rst = 1'b1;
    #1;
    check("t6 rst empty", bus.oitf_empty, 1);
    check("t6 rst dis_ready", bus.dis_ready, 1);
    check("t6 rst match_rs1", bus.oitfrd_match_disprs1, 0);
    check("t6 rst match_rs2", bus.oitfrd_match_disprs2, 0);
    check("t6 rst match_rd", bus.oitfrd_match_disprd, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // Fill, retire twice with wrap
    drive(1, 1, 1, 0, 0, 0, 0, 0); step();
    drive(1, 1, 2, 0, 0, 0, 0, 0); step(); idle(); #1;
    check("t3 full", bus.dis_ready, 0);
    check("t3 ret_ptr0", bus.oitf_ret_ptr, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1); step(); idle(); #1;
    check("t3 ret_ptr1", bus.oitf_ret_ptr, 1);
    check("t3 head rd2", bus.oitf_ret_rdidx, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 1); step(); idle(); #1;
    check("t3 ret_ptr wrap", bus.oitf_ret_ptr, 0);
    check("t3 empty", bus.oitf_empty, 1);

    // Retire while empty is ignored
    drive(0, 0, 0, 0, 0, 0, 0, 1); step(); step(); idle(); #1;
    check("t5 empty", bus.oitf_empty, 1);
    check("t5 ret_ptr", bus.oitf_ret_ptr, 0);
    check("t5 dis_ptr", bus.dis_ptr, 0);

    // Hazard matching against outstanding x7
    drive(1, 1, 7, 0, 0, 0, 0, 0);
    #1 check("t3 third alloc itag", bus.dis_ptr, 0);
    step();
    drive(0, 1, 7, 1, 7, 1, 7, 0); #1;
    check("t4 match_rs1", bus.oitfrd_match_disprs1, 1);
    check("t4 match_rs2", bus.oitfrd_match_disprs2, 1);
    check("t4 match_rd", bus.oitfrd_match_disprd, 1);
    drive(0, 0, 7, 0, 7, 0, 7, 0); #1;
    check("t4 rs1en0", bus.oitfrd_match_disprs1, 0);
    check("t4 rdwen0", bus.oitfrd_match_disprd, 0);
    drive(1, 0, 7, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 1, 7, 1, 7, 0); #1;
    check("t4 entry rdwen0 rs1", bus.oitfrd_match_disprs1, 0);
    check("t4 entry rdwen0 rs2", bus.oitfrd_match_disprs2, 0);
    check("t4 head rdwen", bus.oitf_ret_rdwen, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1); step();
    drive(1, 1, 3, 1, 3, 0, 0, 0); #1;
    check("t4 same-cycle alloc excluded", bus.oitfrd_match_disprs1, 0);
    step();
    drive(0, 0, 0, 1, 3, 0, 0, 0); #1;
    check("t4 next-cycle alloc seen", bus.oitfrd_match_disprs1, 1);

    // Mixed alloc/retire traffic checked by the model
    for (int i = 0; i < 48; i++) begin
      drive((i % 3) != 0, (i % 5) != 0, i * 3, 1, i * 3 - 3, (i % 2) == 0, i * 3 - 6,
            ((i % 2) == 1) || ((i % 7) == 0));
      step();
    end
    idle();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
